// File: rtl/mult_wb_pkg.sv
// ---------------------------------------------------------------------------
// mult_wb_pkg : shared backend constants and the multiplier tag record.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_wb_pkg;

  localparam int MULT_LATENCY = 5;
  localparam int TAG_PREG_W   = 6;
  localparam int TAG_ROB_W    = 6;

  typedef struct packed {
    logic                  valid;
    logic [TAG_PREG_W-1:0] prd;
    logic [TAG_ROB_W-1:0]  rob_idx;
  } mult_tag_t;

endpackage

`default_nettype wire

// File: rtl/mult_wb_fifo.sv
// ---------------------------------------------------------------------------
// mult_wb_fifo : writeback result FIFO, any depth >= 2, flushable.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push_ok, pop_ok;

  // Pointers wrap explicitly so non power-of-two depths stay exact.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && !flush_i && (!full || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/mult_wb.sv
// ---------------------------------------------------------------------------
// mult_wb : multiplier tag pipeline with credit-controlled writeback buffer.
// Config  : MULT_WB_BUFFER_EN enables the FIFO/credit path; otherwise direct.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_wb
  import mult_wb_pkg::*;
#(
  parameter int MULT_LATENCY = mult_wb_pkg::MULT_LATENCY,
  parameter int WB_DEPTH     = 4,
  parameter int PREG_W       = TAG_PREG_W,
  parameter int ROB_W        = TAG_ROB_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              issue_valid_i,
  input  logic [PREG_W-1:0] issue_prd_i,
  input  logic [ROB_W-1:0]  issue_rob_idx_i,
  output logic              issue_ready_o,
  input  logic [31:0]       mult_result_i,
  input  logic              flush_i,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [PREG_W-1:0] wb_prd_o,
  output logic [ROB_W-1:0]  wb_rob_idx_o,
  input  logic              wb_ready_i
);

  logic [MULT_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PREG_W-1:0]       tag_prd_q [MULT_LATENCY];
  logic [ROB_W-1:0]        tag_rob_q [MULT_LATENCY];
  logic                    issue_fire;
  logic                    last_vld;
  logic [PREG_W-1:0]       last_prd;
  logic [ROB_W-1:0]        last_rob;

  assign issue_fire = issue_valid_i && issue_ready_o && !flush_i;
  assign last_vld   = tag_vld_q[MULT_LATENCY-1];
  assign last_prd   = tag_prd_q[MULT_LATENCY-1];
  assign last_rob   = tag_rob_q[MULT_LATENCY-1];

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = issue_fire;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1] && !flush_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) tag_vld_q <= '0;
    else         tag_vld_q <= tag_vld_d;
  end

  // Tag payload is qualified by tag_vld_q, so it needs no reset.
  always_ff @(posedge clock_i) begin
    tag_prd_q[0] <= issue_prd_i;
    tag_rob_q[0] <= issue_rob_idx_i;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      tag_prd_q[k] <= tag_prd_q[k-1];
      tag_rob_q[k] <= tag_rob_q[k-1];
    end
  end

`ifdef MULT_WB_BUFFER_EN
  localparam int PAY_W  = 32 + PREG_W + ROB_W;
  localparam int FCNT_W = $clog2(WB_DEPTH+1);
  localparam int CRD_W  = $clog2(MULT_LATENCY+WB_DEPTH+1);

  logic [PAY_W-1:0]  head;
  logic              empty;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [CRD_W-1:0]  credit;
  logic              pop;

  assign pop = !empty && wb_ready_i;

  mult_wb_fifo #(
    .DEPTH (WB_DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .push_i      (last_vld),
    .push_data_i ({mult_result_i, last_prd, last_rob}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (empty),
    .count_o     (fifo_cnt)
  );

  // Every in-flight tag already owns a FIFO slot, so the FIFO never overflows.
  always_comb begin
    credit = CRD_W'(fifo_cnt);
    for (int k = 0; k < MULT_LATENCY; k++) begin
      credit = credit + CRD_W'(tag_vld_q[k]);
    end
  end

  assign issue_ready_o = (credit < CRD_W'(WB_DEPTH));
  assign wb_valid_o    = !empty;
  assign {wb_data_o, wb_prd_o, wb_rob_idx_o} = empty ? '0 : head;
`else
  logic unused_w;

  assign issue_ready_o = 1'b1;
  assign wb_valid_o    = last_vld;
  assign wb_data_o     = last_vld ? mult_result_i : '0;
  assign wb_prd_o      = last_vld ? last_prd : '0;
  assign wb_rob_idx_o  = last_vld ? last_rob : '0;
  assign unused_w      = wb_ready_i & (WB_DEPTH > 1);
`endif

endmodule

`default_nettype wire

// File: doc/mult_wb.md
MULT_WB -- requirements
Module: mult_wb

Interface
REQ-001 Parameter MULT_LATENCY, default 5 (shared-package constant), cycles from operand issue to a valid multiplier result.
REQ-002 Parameter WB_DEPTH, default 4, number of writeback buffer entries; legal range 2..16.
REQ-003 Parameter PREG_W, default 6, physical destination register index width.
REQ-004 Parameter ROB_W, default 6, ROB index width.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 issue_valid  in  1  a multiply uop enters the multiplier this cycle.
REQ-008 issue_prd  in  PREG_W  physical destination register of the issuing uop.
REQ-009 issue_rob_idx  in  ROB_W  ROB index of the issuing uop.
REQ-010 issue_ready  out  1  the block can accept an issue this cycle.
REQ-011 mult_result  in  32  combinational result from the multiplier, valid MULT_LATENCY cycles after issue.
REQ-012 flush  in  1  pipeline flush; kills all in-flight and buffered results.
REQ-013 wb_valid  out  1  the writeback beat is valid.
REQ-014 wb_data  out  32  result to write back.
REQ-015 wb_prd  out  PREG_W  destination register of the beat.
REQ-016 wb_rob_idx  out  ROB_W  ROB index of the beat.
REQ-017 wb_ready  in  1  the writeback port accepts the beat this cycle.

Function
REQ-018 A MULT_LATENCY-stage tag shift register of {valid, prd, rob_idx} SHALL advance every cycle; stage 0 loads issue_valid&&issue_ready with the issue fields.
REQ-019 When the last tag stage is valid, mult_result SHALL be pushed into the WB FIFO with its tag in that same cycle.
REQ-020 Issue accepted at edge t SHALL make its tag final at t+MULT_LATENCY; the earliest wb_valid SHALL follow 1 cycle later, from the FIFO head.
REQ-021 Results SHALL leave in issue order, one per cycle, and a beat SHALL complete on wb_valid&&wb_ready.
REQ-022 wb_valid, wb_data, wb_prd and wb_rob_idx SHALL stay stable while wb_valid&&!wb_ready.
REQ-023 Credit count = valid tag stages + FIFO occupancy; issue_ready SHALL equal (count < WB_DEPTH), so the FIFO can never overflow.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged; a pop from a full FIFO SHALL free one credit, visible the next cycle.
REQ-025 FIFO pointers SHALL be modulo WB_DEPTH and wrap without losing or duplicating an entry.
REQ-026 flush SHALL synchronously clear all tag valids and FIFO occupancy at the next edge; any issue or push in that cycle SHALL be discarded; wb_valid SHALL be 0 in the following cycle.
REQ-027 issue_valid while issue_ready=0 SHALL be ignored, with no state change.

Reset
REQ-028 reset SHALL immediately clear all tag valids, FIFO pointers and occupancy; wb_valid=0, wb_data=0, wb_prd=0, wb_rob_idx=0, issue_ready=1.
REQ-029 Reset asserted mid-operation SHALL drop every in-flight and buffered result, and no stale beat SHALL appear after release.

Configuration
REQ-030 Macro MULT_WB_BUFFER_EN defined: the WB FIFO and credit logic SHALL be present as described above.
REQ-031 Macro MULT_WB_BUFFER_EN undefined:
- no FIFO; wb_* SHALL be driven combinationally from the last tag stage and mult_result;
- issue_ready SHALL be tied to 1;
- wb_ready SHALL be ignored, with the writeback port guaranteed to accept.

Structure
REQ-032 The shared backend package SHALL hold MULT_LATENCY and a mult_tag_t struct {valid, prd, rob_idx}.
REQ-033 The FIFO SHALL be a sub-module named mult_wb_fifo, parameterised by depth and payload width.

Verification
REQ-034 Single issue at cycle 0 (prd=5, rob=3), mult_result=0x0000_0006 at cycle 5 -> wb_valid=1 at cycle 6 with data 6, prd 5, rob 3.
REQ-035 Back-to-back issues at cycles 0..3, wb_ready=1 -> four beats on cycles 6..9, in order.
REQ-036 wb_ready=0 for 20 cycles under continuous issue -> issue_ready drops after 4 accepted issues, no result is lost, and all 4 drain in order once wb_ready=1.
REQ-037 flush at cycle 3 with 3 uops in flight and 1 buffered -> no wb_valid afterwards, and issue_ready=1 at cycle 4.
REQ-038 reset asserted asynchronously mid-drain -> all outputs are 0 and issue_ready=1 immediately, with no beat after release.
REQ-039 FIFO wrap: 10 cycles of issue with wb_ready toggling every cycle -> 10 beats, correct order and tags, no duplicates.
